// File: rtl/harmonic_phase_sequencer.sv
// rtl/harmonic_phase_sequencer.sv - per-tick harmonic angle issue with amplitude and term markers aligned to the multiplier
module harmonic_phase_sequencer #(
  parameter int WIDTH     = 24,
  parameter int N_HARM    = 8,
  parameter int IDX_W     = 3,
  parameter int ALIGN_DLY = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_tick_i,
  input  logic [WIDTH-1:0] freq_word_i,
  input  logic [IDX_W:0]   harm_count_i,
  input  logic             amp_we_i,
  input  logic [IDX_W-1:0] amp_addr_i,
  input  logic [WIDTH-1:0] amp_data_i,
  output logic             send_o,
  output logic [WIDTH-1:0] angle_o,
  output logic [IDX_W-1:0] harm_idx_o,
  output logic [WIDTH-1:0] harmo_amp_o,
  output logic             term_valid_o,
  output logic             term_last_o,
  output logic             busy_o,
  output logic             overrun_o
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  localparam logic [IDX_W:0]   H_MAX   = (IDX_W+1)'(N_HARM);
  localparam logic [IDX_W:0]   H_ONE   = 1;
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     phase_acc_q, phase_acc_d;
  logic [WIDTH-1:0]     h_angle_q, h_angle_d;
  logic [WIDTH-1:0]     step_q, step_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W:0]       h_q, h_d;
  logic                 overrun_q, overrun_d;
  logic [WIDTH-1:0]     amp_bank_q [N_HARM];
  logic [WIDTH-1:0]     amp_bank_d [N_HARM];
  logic [WIDTH-1:0]     amp_dly_q [ALIGN_DLY];
  logic [WIDTH-1:0]     amp_dly_d [ALIGN_DLY];
  logic [ALIGN_DLY-1:0] valid_dly_q, valid_dly_d;
  logic [ALIGN_DLY-1:0] last_dly_q, last_dly_d;

  logic                 issuing;
  logic                 last_issue;
  logic [WIDTH-1:0]     new_phase;
  logic [IDX_W:0]       h_clamped;

  always_comb begin
    issuing    = (state_q == ISSUE);
    last_issue = issuing && ({1'b0, idx_q} == (h_q - H_ONE));
    new_phase  = phase_acc_q + freq_word_i;
    if (harm_count_i == '0)
      h_clamped = H_ONE;
    else if (harm_count_i > H_MAX)
      h_clamped = H_MAX;
    else
      h_clamped = harm_count_i;
  end

  // h_angle/idx freeze on the last issue cycle so angle_o holds between frames
  always_comb begin
    state_d     = state_q;
    phase_acc_d = phase_acc_q;
    h_angle_d   = h_angle_q;
    step_d      = step_q;
    idx_d       = idx_q;
    h_d         = h_q;
    overrun_d   = overrun_q;
    case (state_q)
      IDLE: begin
        if (sample_tick_i) begin
          phase_acc_d = new_phase;
          h_angle_d   = new_phase;
          step_d      = new_phase;
          idx_d       = '0;
          h_d         = h_clamped;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (sample_tick_i)
          overrun_d = 1'b1;
        if (last_issue) begin
          state_d = IDLE;
        end else begin
          h_angle_d = h_angle_q + step_q;
          idx_d     = idx_q + IDX_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bank reads use the registered contents, so a same-cycle write is seen only by later issues
  always_comb begin
    amp_bank_d = amp_bank_q;
    if (amp_we_i)
      amp_bank_d[amp_addr_i] = amp_data_i;

    amp_dly_d[0]   = issuing ? amp_bank_q[idx_q] : '0;
    valid_dly_d[0] = issuing;
    last_dly_d[0]  = last_issue;
    for (int i = 1; i < ALIGN_DLY; i++) begin
      amp_dly_d[i]   = amp_dly_q[i-1];
      valid_dly_d[i] = valid_dly_q[i-1];
      last_dly_d[i]  = last_dly_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_acc_q <= '0;
      h_angle_q   <= '0;
      step_q      <= '0;
      idx_q       <= '0;
      h_q         <= '0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < N_HARM; i++)
        amp_bank_q[i] <= '0;
      for (int i = 0; i < ALIGN_DLY; i++)
        amp_dly_q[i] <= '0;
      valid_dly_q <= '0;
      last_dly_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_acc_q <= phase_acc_d;
      h_angle_q   <= h_angle_d;
      step_q      <= step_d;
      idx_q       <= idx_d;
      h_q         <= h_d;
      overrun_q   <= overrun_d;
      amp_bank_q  <= amp_bank_d;
      amp_dly_q   <= amp_dly_d;
      valid_dly_q <= valid_dly_d;
      last_dly_q  <= last_dly_d;
    end
  end

  assign send_o       = issuing;
  assign busy_o       = issuing;
  assign angle_o      = h_angle_q;
  assign harm_idx_o   = idx_q;
  assign harmo_amp_o  = amp_dly_q[ALIGN_DLY-1];
  assign term_valid_o = valid_dly_q[ALIGN_DLY-1];
  assign term_last_o  = last_dly_q[ALIGN_DLY-1];
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_harmonic_phase_sequencer.sv
// tb/tb_harmonic_phase_sequencer.sv - scoreboard bench for harmonic_phase_sequencer
module tb_harmonic_phase_sequencer;

  localparam int WIDTH     = 24;
  localparam int N_HARM    = 8;
  localparam int IDX_W     = 3;
  localparam int ALIGN_DLY = 25;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sample_tick_i = 1'b0;
  logic [WIDTH-1:0] freq_word_i = '0;
  logic [IDX_W:0]   harm_count_i = '0;
  logic             amp_we_i = 1'b0;
  logic [IDX_W-1:0] amp_addr_i = '0;
  logic [WIDTH-1:0] amp_data_i = '0;
  logic             send_o;
  logic [WIDTH-1:0] angle_o;
  logic [IDX_W-1:0] harm_idx_o;
  logic [WIDTH-1:0] harmo_amp_o;
  logic             term_valid_o;
  logic             term_last_o;
  logic             busy_o;
  logic             overrun_o;

  harmonic_phase_sequencer #(
    .WIDTH(WIDTH), .N_HARM(N_HARM), .IDX_W(IDX_W), .ALIGN_DLY(ALIGN_DLY)
  ) dut (
    .clk(clk), .reset(reset), .sample_tick_i(sample_tick_i),
    .freq_word_i(freq_word_i), .harm_count_i(harm_count_i),
    .amp_we_i(amp_we_i), .amp_addr_i(amp_addr_i), .amp_data_i(amp_data_i),
    .send_o(send_o), .angle_o(angle_o), .harm_idx_o(harm_idx_o),
    .harmo_amp_o(harmo_amp_o), .term_valid_o(term_valid_o),
    .term_last_o(term_last_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] val;
    int               idx;
    logic             last;
  } exp_t;

  exp_t             sq[$];
  exp_t             tq[$];
  int               cyc = 0;
  int               n_checks = 0;
  int               n_errors = 0;
  logic [WIDTH-1:0] m_phase = '0;
  logic [WIDTH-1:0] m_amp [N_HARM];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: output present with empty scoreboard (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (send_o) begin
        if (sq.size() == 0) flag("send_unexpected");
        else begin
          e = sq.pop_front();
          chk("send_cycle", 32'(cyc), 32'(e.cyc));
          chk("angle", 32'(angle_o), 32'(e.val));
          chk("harm_idx", 32'(harm_idx_o), 32'(e.idx));
          chk("busy", 32'(busy_o), 32'd1);
        end
      end
      if (term_valid_o) begin
        if (tq.size() == 0) flag("term_unexpected");
        else begin
          e = tq.pop_front();
          chk("term_cycle", 32'(cyc), 32'(e.cyc));
          chk("harmo_amp", 32'(harmo_amp_o), 32'(e.val));
          chk("term_last", 32'(term_last_o), 32'(e.last));
        end
      end else begin
        chk("amp_idle_zero", 32'(harmo_amp_o), 32'd0);
        chk("last_idle_zero", 32'(term_last_o), 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_amp(input int addr, input logic [WIDTH-1:0] data);
    @(negedge clk); #1;
    amp_we_i = 1'b1; amp_addr_i = IDX_W'(addr); amp_data_i = data;
    m_amp[addr] = data;
    @(negedge clk); #1;
    amp_we_i = 1'b0;
  endtask

  task automatic start_frame(input logic [WIDTH-1:0] fw, input logic [IDX_W:0] hc);
    int          h;
    logic [31:0] prod;
    exp_t        e;
    @(negedge clk); #1;
    freq_word_i = fw; harm_count_i = hc; sample_tick_i = 1'b1;
    h = (hc == 0) ? 1 : ((int'(hc) > N_HARM) ? N_HARM : int'(hc));
    m_phase = m_phase + fw;
    for (int k = 0; k < h; k++) begin
      prod   = {8'b0, m_phase} * 32'(k + 1);
      e.cyc  = cyc + 1 + k;
      e.val  = prod[WIDTH-1:0];
      e.idx  = k;
      e.last = (k == h - 1);
      sq.push_back(e);
      e.cyc  = cyc + 1 + k + ALIGN_DLY;
      e.val  = m_amp[k];
      tq.push_back(e);
    end
    @(negedge clk); #1;
    sample_tick_i = 1'b0;
  endtask

  task automatic tick_ignored();
    @(negedge clk); #1;
    sample_tick_i = 1'b1;
    @(negedge clk); #1;
    sample_tick_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_send"}, 32'(send_o), 32'd0);
    chk({tag, "_angle"}, 32'(angle_o), 32'd0);
    chk({tag, "_idx"}, 32'(harm_idx_o), 32'd0);
    chk({tag, "_amp"}, 32'(harmo_amp_o), 32'd0);
    chk({tag, "_tvalid"}, 32'(term_valid_o), 32'd0);
    chk({tag, "_tlast"}, 32'(term_last_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun_o), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1;
    sq.delete(); tq.delete();
    m_phase = '0;
    for (int i = 0; i < N_HARM; i++) m_amp[i] = '0;
    @(negedge clk); #1;
    check_all_zero("reset");
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N_HARM; i++) m_amp[i] = '0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    check_all_zero("por");

    // Basic frame
    write_amp(0, 24'h400000);
    write_amp(1, 24'h200000);
    write_amp(2, 24'h100000);
    start_frame(24'h010000, 4'd3);
    idle(40);

    // Phase wrap across two frames, ticks 10 cycles apart
    do_reset();
    start_frame(24'h600000, 4'd4);
    idle(8);
    start_frame(24'h600000, 4'd4);
    idle(40);

    // Harmonic count clamp
    for (int k = 0; k < N_HARM; k++) write_amp(k, 24'(32'h010101 * 32'(k + 1)));
    start_frame(24'h001000, 4'd0);
    idle(40);
    start_frame(24'h001000, 4'd15);
    idle(45);

    // Overrun: tick 2 cycles after the first is dropped, tick 5 cycles after is taken
    chk("overrun_before", 32'(overrun_o), 32'd0);
    start_frame(24'h020000, 4'd4);
    tick_ignored();
    chk("overrun_set", 32'(overrun_o), 32'd1);
    @(negedge clk);
    start_frame(24'h020000, 4'd4);
    idle(40);
    chk("overrun_sticky", 32'(overrun_o), 32'd1);

    // Write to the index being issued returns the old value; next frame sees the new one
    start_frame(24'h000100, 4'd3);
    @(negedge clk);
    write_amp(2, 24'h7FFFFF);
    idle(40);
    start_frame(24'h000100, 4'd3);
    idle(40);

    // Reset in the middle of a frame drops everything in flight
    start_frame(24'h050000, 4'd4);
    do_reset();
    idle(ALIGN_DLY + 10);

    write_amp(0, 24'h0ABCDE);
    start_frame(24'h111111, 4'd1);
    idle(40);

    chk("send_queue_drained", 32'(sq.size()), 32'd0);
    chk("term_queue_drained", 32'(tq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
